// File: rtl/pixel_source_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pixel_source_arbiter_pkg
//   Shared video constants for the display path: the default frame size
//   (800x600) and the grant encodings of the pixel source arbiter.
// ---------------------------------------------------------------------------
package pixel_source_arbiter_pkg;

    // 800 x 600 pixels per frame.
    localparam int FRAME_PIXELS_DEFAULT = 480000;

    // Grant state of the arbiter. The encoding equals the granted source index.
    typedef enum logic {
        GRANT0 = 1'b0,
        GRANT1 = 1'b1
    } grant_e;

endpackage

// File: rtl/pixel_source_arbiter_frame_counter.sv
// ---------------------------------------------------------------------------
// pixel_frame_counter
//   Counts accepted pixel beats within a frame and wraps after the last pixel.
//
//   Ports:
//     clk   - pixel clock
//     rst   - synchronous, active-high reset (count returns to 0)
//     beat  - one accepted pixel this cycle
//     count - pixels of the current frame already accepted (registered)
//     last  - count is at the last pixel position of the frame
// ---------------------------------------------------------------------------
module pixel_frame_counter
    import pixel_source_arbiter_pkg::*;
#(
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int CNT_W        = $clog2(FRAME_PIXELS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);

    assign last = (count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (beat) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pixel_source_arbiter.sv
// ---------------------------------------------------------------------------
// pixel_source_arbiter
//   Shares the pixel FIFO enqueue port between two pixel-stream producers.
//   Exactly one producer is forwarded at a time; the grant only changes on a
//   frame boundary so no frame is ever built from two sources.
//
//   Handshake: a stream transfers one beat in every cycle where valid and
//   ready are both 1. The granted source sees enq_ready as its ready with
//   zero latency, and its data/valid are muxed straight onto enq_*.
//
//   Ports:
//     pixel_clk, rst            - clock, synchronous active-high reset
//     src0_* / src1_*           - producer streams (data, valid, ready)
//     sel_req, sel_src          - one-cycle switch request and its target
//     alt_mode                  - toggle the grant at every frame boundary
//     enq_data/valid/ready      - FIFO enqueue port
//     active_src                - current grant (this is the FSM state)
//     switch_pending            - a requested switch waits for a boundary
//     frame_done                - pulse the cycle after a frame's last beat
//     pixel_count               - pixels of the current frame accepted
//
//   Build option PIXEL_ARB_DRAIN_EN: the non-granted source is drained
//   (ready = 1, pixels dropped) and tracked by its own frame counter; a
//   switch then waits until both sources sit at a frame start together.
// ---------------------------------------------------------------------------
module pixel_source_arbiter
    import pixel_source_arbiter_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int FRAME_PIXELS = FRAME_PIXELS_DEFAULT,
    parameter int CNT_W        = $clog2(FRAME_PIXELS)
) (
    input  logic             pixel_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] src0_data,
    input  logic             src0_valid,
    output logic             src0_ready,
    input  logic [WIDTH-1:0] src1_data,
    input  logic             src1_valid,
    output logic             src1_ready,
    input  logic             sel_req,
    input  logic             sel_src,
    input  logic             alt_mode,
    output logic [WIDTH-1:0] enq_data,
    output logic             enq_valid,
    input  logic             enq_ready,
    output logic             active_src,
    output logic             switch_pending,
    output logic             frame_done,
    output logic [CNT_W-1:0] pixel_count
);

    grant_e     state_q, state_d;
    logic       pending_q, pending_d;
    logic       target_q, target_d;
    logic       frame_done_q;
    logic       grant_src;

    logic       beat;        // accepted beat of the granted source
    logic       cur_last;    // granted source is at its last pixel
    logic       boundary;    // boundary beat of the granted source
    logic       alt_switch;  // alt_mode may toggle in this cycle
    logic       req_switch;  // a pending request may be applied in this cycle

    assign grant_src = (state_q == GRANT1);

    // Pure mux from the granted source.
    always_comb begin
        enq_data  = grant_src ? src1_data  : src0_data;
        enq_valid = grant_src ? src1_valid : src0_valid;
    end

`ifdef PIXEL_ARB_DRAIN_EN
    logic             beat0, beat1;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic             last0, last1;
    logic             zero0_next, zero1_next;

    assign src0_ready = grant_src ? 1'b1 : enq_ready;
    assign src1_ready = grant_src ? enq_ready : 1'b1;
    assign beat0      = src0_valid & src0_ready;
    assign beat1      = src1_valid & src1_ready;

    // Each counter follows one producer's frame position, granted or not.
    pixel_frame_counter #(.FRAME_PIXELS(FRAME_PIXELS), .CNT_W(CNT_W)) u_cnt0 (
        .clk(pixel_clk), .rst(rst), .beat(beat0), .count(cnt0), .last(last0)
    );
    pixel_frame_counter #(.FRAME_PIXELS(FRAME_PIXELS), .CNT_W(CNT_W)) u_cnt1 (
        .clk(pixel_clk), .rst(rst), .beat(beat1), .count(cnt1), .last(last1)
    );

    assign beat        = grant_src ? beat1 : beat0;
    assign cur_last    = grant_src ? last1 : last0;
    assign pixel_count = grant_src ? cnt1  : cnt0;

    // Both counters will read 0 next cycle: both producers at a frame start.
    assign zero0_next = beat0 ? last0 : (cnt0 == '0);
    assign zero1_next = beat1 ? last1 : (cnt1 == '0);

    assign boundary   = beat & cur_last;
    assign alt_switch = boundary & zero0_next & zero1_next;
    assign req_switch = zero0_next & zero1_next;
`else
    assign src0_ready = ~grant_src & enq_ready;
    assign src1_ready =  grant_src & enq_ready;
    assign beat       = enq_valid & enq_ready;

    pixel_frame_counter #(.FRAME_PIXELS(FRAME_PIXELS), .CNT_W(CNT_W)) u_cnt (
        .clk(pixel_clk), .rst(rst), .beat(beat), .count(pixel_count), .last(cur_last)
    );

    assign boundary   = beat & cur_last;
    assign alt_switch = boundary;
    assign req_switch = boundary;
`endif

    // Next-state logic. A request arriving in the switch cycle itself is
    // folded in first, so it takes part in that cycle's grant decision.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        target_d  = target_q;

        if (sel_req) begin
            if (sel_src != grant_src) begin
                pending_d = 1'b1;
                target_d  = sel_src;
            end else begin
                pending_d = 1'b0;
            end
        end

        if (alt_mode) begin
            if (alt_switch) begin
                state_d   = grant_src ? GRANT0 : GRANT1;
                pending_d = 1'b0;
            end
        end else if (req_switch && pending_d) begin
            state_d   = target_d ? GRANT1 : GRANT0;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q      <= GRANT0;
            pending_q    <= 1'b0;
            target_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            target_q     <= target_d;
            frame_done_q <= boundary;
        end
    end

    assign active_src     = grant_src;
    assign switch_pending = pending_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_pixel_source_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pixel_source_arbiter
//   Randomized bench for pixel_source_arbiter (default build, 16-pixel
//   frames). A behavioural model tracks grant, frame position and pending
//   request from the arbiter's rules; a scoreboard queue holds the pixels
//   expected on the enqueue port; a frame tracker checks that every frame
//   holds 16 beats from a single source (src0 pixels have bit 7 = 0,
//   src1 pixels have bit 7 = 1).
// ---------------------------------------------------------------------------
module tb_pixel_source_arbiter;

  localparam int WIDTH = 8;
  localparam int FP    = 16;
  localparam int CNT_W = 4;

  // ---------------- clock / reset ----------------
  logic             pixel_clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] src0_data, src1_data;
  logic             src0_valid, src1_valid;
  logic             src0_ready, src1_ready;
  logic             sel_req, sel_src, alt_mode;
  logic [WIDTH-1:0] enq_data;
  logic             enq_valid, enq_ready;
  logic             active_src, switch_pending, frame_done;
  logic [CNT_W-1:0] pixel_count;

  always #5 pixel_clk = ~pixel_clk;

  pixel_source_arbiter #(.WIDTH(WIDTH), .FRAME_PIXELS(FP), .CNT_W(CNT_W)) dut (
    .pixel_clk(pixel_clk), .rst(rst),
    .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(src0_ready),
    .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(src1_ready),
    .sel_req(sel_req), .sel_src(sel_src), .alt_mode(alt_mode),
    .enq_data(enq_data), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .active_src(active_src), .switch_pending(switch_pending),
    .frame_done(frame_done), .pixel_count(pixel_count)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int m_grant = 0, m_count = 0, m_pending = 0, m_target = 0, m_done = 0;
  logic [WIDTH-1:0] exp_q[$];

  // frame tracker (from observed enqueue traffic)
  int fr_beats = 0, fr_src = 0, fr_mixed = 0;

  // One cycle: inputs were set at the falling edge; sample 1 time unit later,
  // compare, advance the model, then move to the next falling edge.
  task automatic step();
    int   m_beat, bnd;
    logic [WIDTH-1:0] d;
    #1;
    check("enq_valid",      enq_valid,      m_grant ? src1_valid : src0_valid);
    check("enq_data",       enq_data,       m_grant ? src1_data  : src0_data);
    check("src0_ready",     src0_ready,     (m_grant == 0) ? enq_ready : 1'b0);
    check("src1_ready",     src1_ready,     (m_grant == 1) ? enq_ready : 1'b0);
    check("active_src",     active_src,     m_grant);
    check("switch_pending", switch_pending, m_pending);
    check("pixel_count",    pixel_count,    m_count);
    check("frame_done",     frame_done,     m_done);

    if (rst) begin
      exp_q.delete();
      fr_beats = 0; fr_mixed = 0;
      m_grant = 0; m_count = 0; m_pending = 0; m_target = 0; m_done = 0;
    end else begin
      m_beat = ((m_grant ? src1_valid : src0_valid) && enq_ready) ? 1 : 0;
      bnd    = (m_beat != 0 && m_count == FP - 1) ? 1 : 0;
      if (m_beat != 0) exp_q.push_back(m_grant ? src1_data : src0_data);

      // scoreboard on the observed enqueue port
      if (frame_done) begin
        check("frame_len",   fr_beats, FP);
        check("frame_mixed", fr_mixed, 0);
        fr_beats = 0; fr_mixed = 0;
      end
      if (enq_valid && enq_ready) begin
        if (exp_q.size() == 0) check("sb_extra_beat", 1, 0);
        else begin
          d = exp_q.pop_front();
          check("sb_data", enq_data, d);
        end
        if (fr_beats == 0) fr_src = int'(enq_data[WIDTH-1]);
        else if (int'(enq_data[WIDTH-1]) != fr_src) fr_mixed = 1;
        fr_beats++;
      end

      // rules: count, frame pulse, request, boundary grant update
      if (m_beat != 0) m_count = (m_count + 1) % FP;
      m_done = bnd;
      if (sel_req) begin
        if (int'(sel_src) != m_grant) begin m_pending = 1; m_target = int'(sel_src); end
        else m_pending = 0;
      end
      if (bnd != 0) begin
        if (alt_mode) begin m_grant = 1 - m_grant; m_pending = 0; end
        else if (m_pending != 0) begin m_grant = m_target; m_pending = 0; end
      end
    end
    @(posedge pixel_clk);
    @(negedge pixel_clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_data();
    src0_data = 8'($urandom_range(0, 127));
    src1_data = 8'($urandom_range(128, 255));
  endtask

  task automatic drive_stream(input int ready_pct, input int valid_pct);
    drive_data();
    src0_valid = ($urandom_range(0, 99) < valid_pct);
    src1_valid = ($urandom_range(0, 99) < valid_pct);
    enq_ready  = ($urandom_range(0, 99) < ready_pct);
    sel_req    = 1'b0;
  endtask

  // Run a continuous stream until the model reaches frame position n.
  task automatic wait_count(input int n, input string tag);
    int reached = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_count == n) begin reached = 1; break; end
      drive_stream(100, 100);
      step();
    end
    check(tag, reached, 1);
    drive_stream(100, 100);
  endtask

  task automatic wait_grant(input int g, input string tag);
    int reached = 0;
    for (int i = 0; i < 64; i++) begin
      if (m_grant == g) begin reached = 1; break; end
      drive_stream(100, 100);
      step();
    end
    check(tag, reached, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ramp = 0;
    rst = 1'b1; sel_req = 1'b0; sel_src = 1'b0; alt_mode = 1'b0;
    src0_valid = 1'b0; src1_valid = 1'b0; enq_ready = 1'b0;
    src0_data = '0; src1_data = 8'h80;
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    step();                       // still in reset, checks reset state
    rst = 1'b0;

    // src0 ramp, FIFO always ready
    for (int i = 0; i < 40; i++) begin
      drive_stream(100, 100);
      src0_data = 8'(ramp % 128);
      ramp++;
      step();
    end

    // request src1 mid-frame
    wait_count(5, "reach_count5");
    sel_req = 1'b1; sel_src = 1'b1;
    step();
    check("pending_after_req", switch_pending, 1'b1);
    check("still_src0", active_src, 1'b0);
    wait_grant(1, "switch_to_src1");
    check("count_after_switch", pixel_count, 0);
    for (int i = 0; i < 8; i++) begin drive_stream(100, 100); step(); end

    // request arriving in the boundary cycle itself
    wait_count(15, "reach_count15");
    sel_req = 1'b1; sel_src = 1'b0;
    step();
    check("boundary_req_switch", active_src, 1'b0);
    check("boundary_req_pending", switch_pending, 1'b0);

    // request then cancel within one frame
    wait_count(3, "reach_count3");
    sel_req = 1'b1; sel_src = 1'b1;
    step();
    wait_count(8, "reach_count8");
    sel_req = 1'b1; sel_src = 1'b0;
    step();
    check("cancel_clears_pending", switch_pending, 1'b0);
    for (int i = 0; i < 20; i++) begin drive_stream(100, 100); step(); end
    check("cancel_no_switch", active_src, 1'b0);

    // alternate mode with a stalling FIFO
    alt_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      drive_stream(50, 85);
      if ($urandom_range(0, 19) == 0) begin sel_req = 1'b1; sel_src = 1'($urandom_range(0, 1)); end
      step();
    end
    alt_mode = 1'b0;

    // reset in the middle of a GRANT1 frame
    drive_stream(100, 100);
    sel_req = 1'b1; sel_src = 1'b1;
    step();
    wait_grant(1, "grant1_before_rst");
    wait_count(9, "reach_count9");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_grant0", active_src, 1'b0);
    check("rst_count0", pixel_count, 0);
    check("rst_pending0", switch_pending, 1'b0);

    // fully random traffic
    for (int i = 0; i < 600; i++) begin
      drive_stream($urandom_range(30, 100), $urandom_range(50, 100));
      if ($urandom_range(0, 9) == 0) begin sel_req = 1'b1; sel_src = 1'($urandom_range(0, 1)); end
      if ($urandom_range(0, 29) == 0) alt_mode = ~alt_mode;
      rst = ($urandom_range(0, 249) == 0);
      step();
    end
    rst = 1'b0;
    drive_stream(0, 0);
    step();

    // ---------------- final report ----------------
    check("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_source_arbiter.md
# pixel_source_arbiter

Frame-aligned arbiter that shares the pixel FIFO enqueue port between two 8-bit pixel-stream producers (e.g. the test-pattern generator and a second image source). It sits between the producers and the FIFO. It forwards exactly one producer's ready/valid stream at a time and changes the grant only on a frame boundary, so the display controller never receives a frame mixed from two sources. Selection comes from a button-pulse request or from an automatic alternate-every-frame mode.

## Interface
- `WIDTH`, 8: pixel data width.
- `FRAME_PIXELS`, 480000: pixels per frame (800x600).
- `CNT_W`, `$clog2(FRAME_PIXELS)`: pixel counter width.
- `pixel_clk` in 1: the single clock. Everything is in this domain.
- `rst` in 1: synchronous, active-high reset.
- `src0_data` in WIDTH; `src0_valid` in 1; `src0_ready` out 1: producer 0 stream.
- `src1_data` in WIDTH; `src1_valid` in 1; `src1_ready` out 1: producer 1 stream.
- `sel_req` in 1: one-cycle pulse requesting a switch to the source on `sel_src`.
- `sel_src` in 1: requested source index, sampled only when `sel_req` = 1.
- `alt_mode` in 1: level. When 1, the grant toggles at every frame boundary.
- `enq_data` out WIDTH; `enq_valid` out 1; `enq_ready` in 1: connects to the FIFO enqueue port.
- `active_src` out 1: current grant.
- `switch_pending` out 1: a requested switch is waiting for the frame boundary.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame is accepted.
- `pixel_count` out CNT_W: pixels of the current frame already accepted.

## Operation
- State machine with two states, GRANT0 and GRANT1.
  - Reset state is GRANT0.
  - Reset values: `pixel_count` = 0, `switch_pending` = 0, `frame_done` = 0, pending target = 0.
- Datapath is combinational, selected by the grant:
  - `enq_data` and `enq_valid` come from the granted source.
  - The granted source's ready = `enq_ready`.
  - The non-granted source's ready = 0, except as described under Configuration.
- A beat is one cycle with `enq_valid` and `enq_ready` both 1. Each beat increments `pixel_count`.
- On the beat where `pixel_count` = FRAME_PIXELS-1 (the boundary beat):
  - `pixel_count` wraps to 0.
  - `frame_done` pulses in the next cycle.
  - The grant update below is applied.
- Grant update at the boundary:
  - If `alt_mode` = 1, the grant toggles. `alt_mode` takes priority over any pending request, and the pending request is cleared.
  - Else, if a request is pending (including a `sel_req` arriving in the boundary cycle itself), the grant becomes the pending target and pending is cleared.
  - Otherwise the grant is unchanged.
- Request handling:
  - `sel_req` with `sel_src` ≠ grant sets pending and sets the target to `sel_src`.
  - `sel_req` with `sel_src` = grant clears pending.
  - A later `sel_req` overwrites an earlier pending target.
- Reset asserted mid-frame returns the block to GRANT0 with count 0 on the next edge. In-flight pixels of the partial frame are abandoned. Upstream producers must be reset together with this block.

## Timing
- Zero-cycle latency from the granted source to `enq_*` (pure mux). Ready goes back to the granted source combinationally.
- A grant change takes effect in the cycle after the boundary beat. The boundary beat itself still belongs to the old source.
- `active_src`, `switch_pending`, `pixel_count` and `frame_done` are registered outputs.
- No beat is lost or duplicated at a switch: the count of beats in each frame is exactly FRAME_PIXELS.
- `enq_valid` low, or `enq_ready` low, stalls counting. The grant cannot change while the boundary beat is stalled.

## Configuration
- `PIXEL_ARB_DRAIN_EN` defined:
  - The non-granted source's ready is tied to 1 and its pixels are discarded.
  - A second counter tracks the non-granted source's frame position.
  - A pending switch waits until both counters are 0 in the same cycle, so the new source starts on its own frame start.
- `PIXEL_ARB_DRAIN_EN` undefined:
  - The non-granted source's ready = 0 (it is back-pressured).
  - Only one counter exists.

## Structure
- The FRAME_PIXELS default and the GRANT0/GRANT1 encodings belong in the shared video constants header used by the display path.
- One natural sub-module, `pixel_frame_counter`:
  - Inputs: beat, rst.
  - Outputs: count and a `last` flag.
  - Instantiated once, or twice when `PIXEL_ARB_DRAIN_EN` is defined.

## Test plan
- Use FRAME_PIXELS = 16 in simulation.
- Reset, src0 continuous ramp, `enq_ready` = 1 → `enq_data` = src0 values; `frame_done` pulses every 16 cycles; `src1_ready` = 0 (without the macro).
- `sel_req` with `sel_src` = 1 at `pixel_count` = 5 → `switch_pending` = 1; beats 5..15 still from src0; the first beat after the boundary is from src1; `active_src` = 1.
- `sel_req`/`sel_src` = 1 in the boundary cycle (count = 15, beat) → switch happens at that boundary.
- `sel_req` to 1 then to 0 in the same frame → pending cleared; no switch.
- `alt_mode` = 1 with random `enq_ready` (50%) → grant alternates every 16 accepted beats; total beats per frame = 16, none dropped.
- `rst` pulsed at `pixel_count` = 9 in GRANT1 → next cycle GRANT0, count 0, `switch_pending` 0.
